// File: rtl/if_bus_rr_arbiter.sv
// Round-robin, packet-locking arbiter that shares one valid/ready bus among NREQ requesters.
// Optional stall watchdog enabled by defining ARB_TIMEOUT_EN.
module if_bus_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    bus_valid,
  output logic                    bus_last,
  output logic [DW-1:0]           bus_data,
  input  logic                    bus_ready,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout_pulse
);
  localparam int GW = $clog2(NREQ);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] rr_ptr, rr_ptr_nxt, grant_nxt, grant_inc;
  logic [GW-1:0] win_id, scan_idx;
  logic          win_found, xfer, wd_fire;

  // Explicit wrap so non-power-of-2 NREQ never points past the last requester.
  assign grant_inc = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);

  // Scan from the highest offset down so the first valid after rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = GW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // Owner pass-through; bus_valid depends only on req_valid and state, never on bus_ready.
  always_comb begin
    bus_valid = 1'b0;
    bus_last  = 1'b0;
    bus_data  = '0;
    req_ready = '0;
    if (state == LOCKED) begin
      bus_valid           = req_valid[grant_id];
      bus_last            = req_last[grant_id];
      bus_data            = req_data[int'(grant_id)*DW +: DW];
      req_ready[grant_id] = bus_ready;
    end
  end

  assign xfer = bus_valid & bus_ready;
  assign busy = (state == LOCKED);

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_id;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = LOCKED;
          grant_nxt = win_id;
        end
      end
      LOCKED: begin
        if ((xfer && bus_last) || wd_fire) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = grant_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_cnt;

  assign wd_fire = (state == LOCKED) && !xfer && (stall_cnt == SW'(TIMEOUT - 1));

  // Held at zero outside LOCKED so every new grant starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt     <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= wd_fire;
      if (state != LOCKED || xfer || wd_fire) stall_cnt <= '0;
      else                                    stall_cnt <= stall_cnt + SW'(1);
    end
  end
`else
  assign wd_fire       = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_if_bus_rr_arbiter.sv
// Directed bench for if_bus_rr_arbiter: per-requester source queues, an expected-beat
// scoreboard drained by a bus monitor, and cycle-accurate grant/timing checks.
module tb_if_bus_rr_arbiter;
  localparam int NREQ    = 4;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
  localparam int GW      = $clog2(NREQ);
  localparam int EW      = 4 + 1 + DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_last, req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic              bus_valid, bus_last, bus_ready;
  logic [DW-1:0]     bus_data;
  logic [GW-1:0]     grant_id;
  logic              busy, timeout_pulse;

  if_bus_rr_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .bus_valid(bus_valid), .bus_last(bus_last), .bus_data(bus_data),
    .bus_ready(bus_ready), .grant_id(grant_id), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  // Clock / reset control
  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_fail   = 0;
  logic            cfg_rst, cfg_ready, force_all;
  logic [NREQ-1:0] mask, fired;
  logic [DW:0]     src_q [NREQ][$];
  logic [EW-1:0]   exp_q [$];
  logic [EW-1:0]   mon_got, mon_exp;
  int              held;

  function automatic logic [DW-1:0] mk(int r, int p, int b);
    return {8'(r), 8'(p), 16'(b)};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Driver tasks
  task automatic add_src(int r, int p, int n);
    for (int b = 0; b < n; b++) src_q[r].push_back({(b == n - 1), mk(r, p, b)});
  endtask

  task automatic exp_beat(int r, int p, int b, int n);
    logic l;
    l = (b == n - 1);
    exp_q.push_back({4'(r), l, mk(r, p, b)});
  endtask

  task automatic drive_reqs();
    logic [DW:0] h;
    for (int i = 0; i < NREQ; i++) begin
      if (force_all) begin
        req_valid[i] = 1'b1;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = mk(i, 9, 0);
      end else if (src_q[i].size() > 0 && !mask[i]) begin
        h = src_q[i][0];
        req_valid[i] = 1'b1;
        req_last[i]  = h[DW];
        req_data[i*DW +: DW] = h[DW-1:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  // Advance one cycle: retire beats accepted last cycle, apply pending controls, return at negedge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    rst       = cfg_rst;
    bus_ready = cfg_ready;
    drive_reqs();
    @(negedge clk);
  endtask

  always @(negedge clk) fired = req_valid & req_ready;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b0 && bus_valid === 1'b1 && bus_ready === 1'b1) begin
      mon_got = {4'(grant_id), bus_last, bus_data};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got %0h expected none at %0t", mon_got, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL beat_data: got %0h expected %0h at %0t", mon_got, mon_exp, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int gseq [5] = '{0, 1, 2, 3, 0};
    cfg_rst = 1'b1; cfg_ready = 1'b0; force_all = 1'b1; mask = '0;
    rst = 1'b1; bus_ready = 1'b0;
    drive_reqs();

    // Reset held for three edges with every requester valid
    @(negedge clk);
    chk("rst_hold0", {bus_valid, req_ready, busy, grant_id}, 0);
    step();
    chk("rst_hold1", {bus_valid, req_ready, busy, grant_id}, 0);
    cfg_rst = 1'b0;
    step();
    chk("rst_hold2", {bus_valid, req_ready, busy, grant_id}, 0);
    step();
    chk("rst_grant", {busy, grant_id}, {1'b1, 2'd0});
    cfg_rst = 1'b1; force_all = 1'b0;
    step();
    step();
    cfg_rst = 1'b0; cfg_ready = 1'b1;
    step();

    // Round robin: 2-beat packets, pattern IDLE / beat0 / beat1(last)
    add_src(0, 0, 2); add_src(1, 0, 2); add_src(2, 0, 2); add_src(3, 0, 2); add_src(0, 1, 2);
    for (int k = 0; k < 5; k++) begin
      exp_beat(gseq[k], k / 4, 0, 2);
      exp_beat(gseq[k], k / 4, 1, 2);
    end
    for (int c = 0; c < 15; c++) begin
      step();
      case (c % 3)
        0:       chk("rr_idle", {busy, bus_valid}, 2'b00);
        1:       chk("rr_beat0", {busy, bus_valid, bus_last, grant_id}, {3'b110, 2'(gseq[c/3])});
        default: chk("rr_beat1", {busy, bus_valid, bus_last, grant_id}, {3'b111, 2'(gseq[c/3])});
      endcase
    end

    // Lock hold: owner 1 goes quiet mid-packet while requester 2 waits
    add_src(1, 2, 2); add_src(2, 2, 1);
    exp_beat(1, 2, 0, 2); exp_beat(1, 2, 1, 2); exp_beat(2, 2, 0, 1);
    step();
    step();
    chk("lock_first", {busy, grant_id, bus_valid}, {1'b1, 2'd1, 1'b1});
    mask[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("lock_hold", {busy, grant_id, req_ready[2], bus_valid}, {1'b1, 2'd1, 1'b0, 1'b0});
    end
    mask[1] = 1'b0;
    step();
    chk("lock_last", {bus_valid, bus_last, grant_id}, {2'b11, 2'd1});
    step();
    chk("lock_gap", busy, 0);
    step();
    chk("lock_next", {busy, grant_id}, {1'b1, 2'd2});

    // Backpressure: 8-beat packet from requester 3, bus_ready low for 7 cycles after beat 2
    add_src(3, 4, 8);
    for (int b = 0; b < 8; b++) exp_beat(3, 4, b, 8);
    step();
    step();
    chk("bp_grant", {busy, grant_id}, {1'b1, 2'd3});
    step();
    step();
    cfg_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      step();
      chk("bp_stall", {bus_valid, req_ready, bus_data}, {1'b1, 4'b0000, mk(3, 4, 3)});
    end
    cfg_ready = 1'b1;
    for (int c = 0; c < 5; c++) step();
    chk("bp_last", {bus_valid, bus_last}, 2'b11);

    // Reset mid-packet: rr_ptr is 2 when reset lands, must restart from 0
    add_src(1, 5, 1); add_src(3, 6, 4);
    exp_beat(1, 5, 0, 1); exp_beat(3, 6, 0, 4); exp_beat(3, 6, 1, 4);
    step();
    step();
    chk("rstm_g1", {busy, grant_id}, {1'b1, 2'd1});
    step();
    step();
    chk("rstm_g3", {busy, grant_id}, {1'b1, 2'd3});
    step();
    cfg_rst = 1'b1;
    step();
    cfg_rst = 1'b0; mask = '1;
    step();
    chk("rstm_drop", {busy, grant_id, bus_valid}, 0);
    src_q[3].delete();
    add_src(1, 7, 1); add_src(3, 8, 1);
    exp_beat(1, 7, 0, 1); exp_beat(3, 8, 0, 1);
    mask = '0;
    step();
    step();
    chk("rstm_regrant", {busy, grant_id}, {1'b1, 2'd1});
    step();
    step();
    chk("rstm_next", {busy, grant_id}, {1'b1, 2'd3});

    // Stalled owner 0: watchdog revoke when enabled, indefinite hold otherwise
    add_src(0, 10, 2); add_src(1, 11, 1);
    step();
    step();
    chk("wd_grant", {busy, grant_id, bus_valid}, {1'b1, 2'd0, 1'b1});
    mask[0] = 1'b1;
    held = 0;
`ifdef ARB_TIMEOUT_EN
    exp_beat(0, 10, 0, 2); exp_beat(1, 11, 0, 1); exp_beat(0, 10, 1, 2);
    for (int c = 0; c < 16; c++) begin
      step();
      if (busy && grant_id == 2'd0 && !timeout_pulse) held++;
    end
    chk("wd_held16", held, 16);
    step();
    chk("wd_pulse", {timeout_pulse, busy}, 2'b10);
    step();
    chk("wd_next", {timeout_pulse, busy, grant_id}, {2'b01, 2'd1});
    mask[0] = 1'b0;
    step();
    step();
    chk("wd_resume", {busy, grant_id, bus_last}, {1'b1, 2'd0, 1'b1});
`else
    exp_beat(0, 10, 0, 2); exp_beat(0, 10, 1, 2); exp_beat(1, 11, 0, 1);
    for (int c = 0; c < 100; c++) begin
      step();
      if (busy && grant_id == 2'd0 && !timeout_pulse) held++;
    end
    chk("hold100", held, 100);
    mask[0] = 1'b0;
    step();
    chk("hold_last", {bus_valid, bus_last, grant_id}, {2'b11, 2'd0});
    step();
    step();
    chk("hold_next", {busy, grant_id}, {1'b1, 2'd1});
`endif

    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step();
    step();
    chk("sb_drained", exp_q.size(), 0);
    chk("src_drained", src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
